// File: rtl/thermal_source_selector.sv
// thermal_source_selector: hysteretic heat/cool/idle controller with source
// selection (solar / ambient / geothermal) and a post-run lockout timer.
// The source and its thresholds are latched at run start and held until the
// run ends. Optional stale-sample watchdog: define STALE_SAMPLE_WATCHDOG_EN.
module thermal_source_selector #(
  parameter int HYST             = 2,
  parameter int MIN_OFF_CYCLES   = 1000,
  parameter int AMBIENT_MIN_TEMP = 0,
  parameter int WDT_CYCLES       = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [7:0]  room_temp,
  input  logic [7:0]  outdoor_temp,
  input  logic [15:0] solar_level,
  input  logic [15:0] solar_th,
  input  logic [7:0]  solar_cooldown_th,
  input  logic [7:0]  solar_heatup_th,
  input  logic [7:0]  ambient_cooldown_th,
  input  logic [7:0]  ambient_heatup_th,
  input  logic [7:0]  geothermal_cooldown_th,
  input  logic [7:0]  geothermal_heatup_th,
  output logic        heat_en,
  output logic        cool_en,
  output logic [1:0]  source,
  output logic        lockout,
  output logic        fault
);
  localparam int CW = 20;
  localparam logic [CW-1:0]     LOCK_LOAD = CW'(MIN_OFF_CYCLES - 1);
  localparam logic signed [8:0] HYST9     = 9'(HYST);
  localparam logic signed [8:0] AMB_MIN9  = 9'(AMBIENT_MIN_TEMP);

  localparam logic [1:0] SRC_NONE = 2'd0, SRC_SOLAR = 2'd1,
                         SRC_AMB  = 2'd2, SRC_GEO   = 2'd3;

  typedef enum logic [1:0] {IDLE, HEATING, COOLING, LOCKOUT} state_t;

  // Sign-extend an 8-bit temperature so compares and the hysteresis sum
  // never wrap at the +/-127 extremes.
  function automatic logic signed [8:0] sx(input logic [7:0] v);
    return {v[7], v};
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    src_q, src_d;
  logic [7:0]    hth_q, hth_d, cth_q, cth_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          heat_q, heat_d, cool_q, cool_d, lock_q, lock_d;
  logic [1:0]    srco_q, srco_d;

  logic [1:0] cand_src;
  logic [7:0] cand_heat, cand_cool;
  logic signed [8:0] room9;

  // Candidate source from the current sample: solar, then ambient, then geo.
  always_comb begin
    room9 = sx(room_temp);
    if (solar_level >= solar_th) begin
      cand_src = SRC_SOLAR; cand_heat = solar_heatup_th; cand_cool = solar_cooldown_th;
    end else if (sx(outdoor_temp) >= AMB_MIN9) begin
      cand_src = SRC_AMB; cand_heat = ambient_heatup_th; cand_cool = ambient_cooldown_th;
    end else begin
      cand_src = SRC_GEO; cand_heat = geothermal_heatup_th; cand_cool = geothermal_cooldown_th;
    end
  end

`ifdef STALE_SAMPLE_WATCHDOG_EN
  logic [31:0] wdt_q, wdt_d;
  logic        fault_q, fault_d;
  logic        wdt_trip;
`endif

  // Next-state logic; outputs are decoded from the next state and registered.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    hth_d   = hth_q;
    cth_d   = cth_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (sample_valid) begin
        if (room9 <= sx(cand_heat)) begin
          state_d = HEATING;
          src_d = cand_src; hth_d = cand_heat; cth_d = cand_cool;
        end else if (room9 >= sx(cand_cool)) begin
          state_d = COOLING;
          src_d = cand_src; hth_d = cand_heat; cth_d = cand_cool;
        end
      end
      HEATING: if (sample_valid && room9 >= sx(hth_q) + HYST9) begin
        state_d = LOCKOUT; cnt_d = LOCK_LOAD;
      end
      COOLING: if (sample_valid && room9 <= sx(cth_q) - HYST9) begin
        state_d = LOCKOUT; cnt_d = LOCK_LOAD;
      end
      LOCKOUT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          src_d = SRC_NONE; hth_d = '0; cth_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef STALE_SAMPLE_WATCHDOG_EN
    // A run that stops receiving samples is aborted into lockout.
    wdt_trip = (state_q == HEATING || state_q == COOLING) && !sample_valid &&
               (wdt_q == 32'(WDT_CYCLES));
    wdt_d    = sample_valid ? '0 :
               (wdt_q == 32'(WDT_CYCLES)) ? wdt_q : wdt_q + 1'b1;
    fault_d  = sample_valid ? 1'b0 : fault_q;
    if (wdt_trip) begin
      state_d = LOCKOUT; cnt_d = LOCK_LOAD;
      wdt_d   = '0;
      fault_d = 1'b1;
    end
`endif
    heat_d = (state_d == HEATING);
    cool_d = (state_d == COOLING);
    lock_d = (state_d == LOCKOUT);
    srco_d = (state_d == HEATING || state_d == COOLING) ? src_d : SRC_NONE;
  end

  // State, latched run context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= SRC_NONE;
      hth_q   <= '0;
      cth_q   <= '0;
      cnt_q   <= '0;
      heat_q  <= 1'b0;
      cool_q  <= 1'b0;
      lock_q  <= 1'b0;
      srco_q  <= SRC_NONE;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      hth_q   <= hth_d;
      cth_q   <= cth_d;
      cnt_q   <= cnt_d;
      heat_q  <= heat_d;
      cool_q  <= cool_d;
      lock_q  <= lock_d;
      srco_q  <= srco_d;
    end
  end

`ifdef STALE_SAMPLE_WATCHDOG_EN
  // Watchdog counter and sticky stale-sample fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign heat_en = heat_q;
  assign cool_en = cool_q;
  assign source  = srco_q;
  assign lockout = lock_q;
endmodule

// File: tb/tb_thermal_source_selector.sv
// Scoreboard bench for thermal_source_selector: stimulus pushes expected
// {heat_en, cool_en, source, lockout, fault} per sample; a monitor pops and
// compares in the cycle the DUT presents the decision.
module tb_thermal_source_selector;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  room_temp = '0, outdoor_temp = '0;
  logic [15:0] solar_level = '0, solar_th = '0;
  logic [7:0]  solar_cooldown_th = '0, solar_heatup_th = '0;
  logic [7:0]  ambient_cooldown_th = '0, ambient_heatup_th = '0;
  logic [7:0]  geothermal_cooldown_th = '0, geothermal_heatup_th = '0;
  logic        heat_en, cool_en, lockout, fault;
  logic [1:0]  source;

  thermal_source_selector #(
    .HYST(2), .MIN_OFF_CYCLES(1000), .AMBIENT_MIN_TEMP(0), .WDT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .room_temp(room_temp), .outdoor_temp(outdoor_temp),
    .solar_level(solar_level), .solar_th(solar_th),
    .solar_cooldown_th(solar_cooldown_th), .solar_heatup_th(solar_heatup_th),
    .ambient_cooldown_th(ambient_cooldown_th), .ambient_heatup_th(ambient_heatup_th),
    .geothermal_cooldown_th(geothermal_cooldown_th),
    .geothermal_heatup_th(geothermal_heatup_th),
    .heat_en(heat_en), .cool_en(cool_en), .source(source),
    .lockout(lockout), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  string      name_q[$];
  logic       probe = 1'b0;
  logic       fire_q = 1'b0;
  logic [5:0] act;

  assign act = {heat_en, cool_en, source, lockout, fault};

  function automatic logic [5:0] e6(input logic h, input logic c,
                                    input logic [1:0] s, input logic l, input logic f);
    return {h, c, s, l, f};
  endfunction

  task automatic check(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // A decision becomes visible the cycle after a sample (or probe) strobe.
  always @(posedge clk) fire_q <= sample_valid | probe;

  // Monitor: pop and compare whenever the DUT presents a decision.
  always @(negedge clk) begin
    if (fire_q) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: output with no expectation");
      end else begin
        logic [5:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, int'(act), int'(e));
      end
    end
  end

  task automatic smp(input string nm, input logic [7:0] room, input logic [5:0] e);
    @(posedge clk); #1;
    room_temp = room;
    sample_valid = 1'b1;
    exp_q.push_back(e); name_q.push_back(nm);
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic probe_chk(input string nm, input logic [5:0] e);
    @(posedge clk); #1;
    probe = 1'b1;
    exp_q.push_back(e); name_q.push_back(nm);
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic wait_lockout(output int n);
    n = 0;
    while (lockout === 1'b1 && n < 1100) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 1100) check("lockout_timeout", n, 1000);
  endtask

  task automatic async_rst(input string nm);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check(nm, int'(act), 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    #2 rst = 1'b1;
    #1 check("reset_outputs", int'(act), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    probe_chk("idle_after_reset", e6(0, 0, 0, 0, 0));

    // Solar heating run with hysteresis exit and full lockout length.
    solar_level = 16'd3000; solar_th = 16'd2550;
    solar_heatup_th = 8'd16; solar_cooldown_th = 8'd30;
    ambient_heatup_th = 8'd10; ambient_cooldown_th = 8'd40;
    geothermal_heatup_th = 8'd12; geothermal_cooldown_th = 8'd35;
    outdoor_temp = 8'd20;
    smp("solar_heat_enter", 8'd14, e6(1, 0, 1, 0, 0));
    smp("solar_heat_hold17", 8'd17, e6(1, 0, 1, 0, 0));
    smp("solar_heat_exit18", 8'd18, e6(0, 0, 0, 1, 0));
    wait_lockout(n);
    check("lockout_len", n, 1000);
    probe_chk("idle_after_lockout", e6(0, 0, 0, 0, 0));

    // Geothermal cooling; a sample during lockout is ignored.
    solar_level = 16'd100; outdoor_temp = -8'sd5;
    smp("geo_cool_enter", 8'd36, e6(0, 1, 3, 0, 0));
    smp("geo_cool_hold34", 8'd34, e6(0, 1, 3, 0, 0));
    smp("geo_cool_exit33", 8'd33, e6(0, 0, 0, 1, 0));
    smp("lockout_ignores_sample", 8'd0, e6(0, 0, 0, 1, 0));
    wait_lockout(n);

    // Latched source/thresholds survive input changes mid-run.
    solar_level = 16'd3000; solar_heatup_th = 8'd16;
    smp("latch_heat_enter", 8'd14, e6(1, 0, 1, 0, 0));
    solar_level = 16'd0; solar_heatup_th = 8'd27;
    smp("latch_hold17", 8'd17, e6(1, 0, 1, 0, 0));
    smp("latch_exit18", 8'd18, e6(0, 0, 0, 1, 0));
    wait_lockout(n);

    // Ambient at the outdoor boundary, overlapping thresholds: heating wins.
    solar_level = 16'd0; outdoor_temp = 8'd0;
    ambient_heatup_th = 8'd10; ambient_cooldown_th = 8'd5;
    smp("amb_overlap_heat", 8'd10, e6(1, 0, 2, 0, 0));
    smp("amb_hold11", 8'd11, e6(1, 0, 2, 0, 0));
    smp("amb_exit12", 8'd12, e6(0, 0, 0, 1, 0));
    wait_lockout(n);

    // Extremes: no 8-bit wrap in compares or hysteresis sums.
    solar_level = 16'd3000; solar_heatup_th = -8'sd12;
    smp("neg128_heat", 8'h80, e6(1, 0, 1, 0, 0));
    smp("neg_exit_m10", -8'sd10, e6(0, 0, 0, 1, 0));
    wait_lockout(n);
    solar_heatup_th = 8'd127;
    smp("pos127_heat", 8'd127, e6(1, 0, 1, 0, 0));
    smp("pos127_no_wrap", 8'd127, e6(1, 0, 1, 0, 0));
    async_rst("rst_mid_heat");
    probe_chk("idle_after_rst1", e6(0, 0, 0, 0, 0));
    solar_heatup_th = 8'h80; solar_cooldown_th = 8'h80;
    smp("neg127_cool", -8'sd127, e6(0, 1, 1, 0, 0));
    smp("neg128_cool_no_wrap", 8'h80, e6(0, 1, 1, 0, 0));
    async_rst("rst_mid_cool");
    probe_chk("idle_after_rst2", e6(0, 0, 0, 0, 0));

`ifdef STALE_SAMPLE_WATCHDOG_EN
    // Stale samples abort a cooling run with a sticky fault.
    solar_level = 16'd100; outdoor_temp = -8'sd5;
    smp("wdt_cool_enter", 8'd36, e6(0, 1, 3, 0, 0));
    n = 0;
    while (fault !== 1'b1 && n < 80) begin
      n++;
      @(posedge clk); #1;
    end
    check("wdt_fault_state", int'(act), int'(e6(0, 0, 0, 1, 1)));
    repeat (5) @(posedge clk);
    #1 check("wdt_fault_sticky", int'(fault), 1);
    smp("wdt_fault_clear", 8'd20, e6(0, 0, 0, 1, 0));
    wait_lockout(n);
`endif

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expectations unconsumed", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
